// File: rtl/pipe_alu_pkg.sv
// Shared opcodes, flag bit positions and FSM/shift-op enums for pipe_alu.
// PIPE_ALU_MUL_EN adds the MUL state and shift-add op.
package pipe_alu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_NOT  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_ADDC = 8'h07;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MUL  = 8'h0E;
    localparam logic [7:0] OP_LSH  = 8'h84;
    localparam logic [7:0] OP_RSH  = 8'h88;
    localparam logic [7:0] OP_ARSH = 8'h8C;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_L = 0;

`ifdef PIPE_ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_e;
    typedef enum logic [1:0] {SH_LSH, SH_RSH, SH_ARSH, SH_MUL} sh_op_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_e;
    typedef enum logic [1:0] {SH_LSH, SH_RSH, SH_ARSH} sh_op_e;
`endif

endpackage

// File: rtl/pipe_alu_shifter.sv
// Iterative one-bit-per-cycle shifter; with PIPE_ALU_MUL_EN also a
// shift-add multiplier. res/cout present the value of the final step.
module pipe_alu_shifter
    import pipe_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  sh_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   k,
`ifdef PIPE_ALU_MUL_EN
    input  logic [WIDTH-1:0] b,
`endif
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    sh_op_e           op_q, op_d;
    logic [CW-1:0]    k_sat;
`ifdef PIPE_ALU_MUL_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mpl_q, mpl_d;
`endif

    assign k_sat = (k > SHW'(WIDTH)) ? CW'(WIDTH) : CW'(k);

    always_comb begin
        work_d = work_q;
        cnt_d  = cnt_q;
        cout_d = cout_q;
        op_d   = op_q;
`ifdef PIPE_ALU_MUL_EN
        acc_d  = acc_q;
        mpl_d  = mpl_q;
`endif
        if (start) begin
            work_d = a;
            cnt_d  = k_sat;
            cout_d = 1'b0;
            op_d   = op;
`ifdef PIPE_ALU_MUL_EN
            acc_d  = '0;
            mpl_d  = b;
            if (op == SH_MUL) cnt_d = CW'(WIDTH);
`endif
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
            unique case (op_q)
                SH_LSH:  {cout_d, work_d} = {work_q, 1'b0};
                SH_RSH:  {work_d, cout_d} = {1'b0, work_q};
                SH_ARSH: {work_d, cout_d} = {work_q[WIDTH-1], work_q};
`ifdef PIPE_ALU_MUL_EN
                SH_MUL: begin
                    if (mpl_q[0]) acc_d = acc_q + work_q;
                    work_d = work_q << 1;
                    mpl_d  = mpl_q >> 1;
                end
`endif
                default: work_d = work_q;
            endcase
        end
    end

    // Last step completes on the edge where the result is captured upstream
    assign done = (cnt_q == CW'(1));
    assign cout = cout_d;
`ifdef PIPE_ALU_MUL_EN
    assign res  = (op_q == SH_MUL) ? acc_d : work_d;
`else
    assign res  = work_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            cnt_q  <= '0;
            cout_q <= 1'b0;
            op_q   <= SH_LSH;
`ifdef PIPE_ALU_MUL_EN
            acc_q  <= '0;
            mpl_q  <= '0;
`endif
        end else begin
            work_q <= work_d;
            cnt_q  <= cnt_d;
            cout_q <= cout_d;
            op_q   <= op_d;
`ifdef PIPE_ALU_MUL_EN
            acc_q  <= acc_d;
            mpl_q  <= mpl_d;
`endif
        end
    end

endmodule

// File: rtl/pipe_alu.sv
// Handshaked ALU with registered result/flags and multi-cycle shifts.
// Define PIPE_ALU_MUL_EN to enable the iterative MUL opcode.
module pipe_alu
    import pipe_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    logic             accept, is_shift, is_mul, sh_start;
    logic             sh_done, sh_cout, upd_z;
    sh_op_e           sh_op;
    logic [WIDTH-1:0] sh_res, alu_r, sub_r;
    logic [4:0]       alu_f;
    logic [WIDTH:0]   add_w, adc_w;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign add_w = {1'b0, a} + {1'b0, b};
    assign adc_w = add_w + {{WIDTH{1'b0}}, flags_q[FLAG_C]};
    assign sub_r = a - b;

    always_comb begin
        sh_op    = SH_LSH;
        is_shift = 1'b0;
        is_mul   = 1'b0;
        unique case (opcode)
            OP_LSH:  begin sh_op = SH_LSH;  is_shift = 1'b1; end
            OP_RSH:  begin sh_op = SH_RSH;  is_shift = 1'b1; end
            OP_ARSH: begin sh_op = SH_ARSH; is_shift = 1'b1; end
`ifdef PIPE_ALU_MUL_EN
            OP_MUL:  begin sh_op = SH_MUL;  is_mul = 1'b1; end
`endif
            default: sh_op = SH_LSH;
        endcase
        // Zero-distance shifts finish in IDLE like any single-cycle op
        if (b[SHW-1:0] == '0) is_shift = 1'b0;
    end

    always_comb begin
        alu_r = '0;
        alu_f = flags_q;
        upd_z = 1'b1;
        unique case (opcode)
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_NOT: alu_r = ~a;
            OP_ADD: begin
                alu_r = add_w[MSB:0];
                alu_f[FLAG_C] = 1'b0;
                alu_f[FLAG_F] = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
                alu_f[FLAG_N] = 1'b0;
                alu_f[FLAG_L] = 1'b0;
            end
            OP_ADDU: begin
                alu_r = add_w[MSB:0];
                alu_f[FLAG_C] = add_w[WIDTH];
                alu_f[FLAG_F] = 1'b0;
                alu_f[FLAG_N] = 1'b0;
                alu_f[FLAG_L] = 1'b0;
            end
            OP_ADDC: begin
                alu_r = adc_w[MSB:0];
                alu_f[FLAG_C] = adc_w[WIDTH];
                alu_f[FLAG_F] = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
                alu_f[FLAG_N] = 1'b0;
                alu_f[FLAG_L] = 1'b0;
            end
            OP_SUB: begin
                alu_r = sub_r;
                alu_f[FLAG_C] = 1'b0;
                alu_f[FLAG_F] = (a[MSB] != b[MSB]) && (sub_r[MSB] != a[MSB]);
                alu_f[FLAG_N] = 1'b0;
                alu_f[FLAG_L] = 1'b0;
            end
            OP_CMP: begin
                upd_z = 1'b0;
                alu_f[FLAG_Z] = (a == b);
                alu_f[FLAG_C] = 1'b0;
                alu_f[FLAG_F] = 1'b0;
                alu_f[FLAG_N] = $signed(a) < $signed(b);
                alu_f[FLAG_L] = a < b;
            end
            OP_LSH, OP_RSH, OP_ARSH: begin
                alu_r = a;
                alu_f[FLAG_C] = 1'b0;
            end
            default: upd_z = 1'b0;
        endcase
        if (upd_z) alu_f[FLAG_Z] = (alu_r == '0);
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
        sh_start    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_shift) begin
                        state_d  = SHIFT;
                        sh_start = 1'b1;
                    end
`ifdef PIPE_ALU_MUL_EN
                    else if (is_mul) begin
                        state_d  = MUL;
                        sh_start = 1'b1;
                    end
`endif
                    else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_r;
                        flags_d     = alu_f;
                    end
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_d        = IDLE;
                    out_valid_d    = 1'b1;
                    result_d       = sh_res;
                    flags_d[FLAG_Z] = (sh_res == '0);
                    flags_d[FLAG_C] = sh_cout;
                end
            end
`ifdef PIPE_ALU_MUL_EN
            MUL: begin
                if (sh_done) begin
                    state_d        = IDLE;
                    out_valid_d    = 1'b1;
                    result_d       = sh_res;
                    flags_d[FLAG_Z] = (sh_res == '0);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    pipe_alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (sh_start),
        .op    (sh_op),
        .a     (a),
        .k     (b[SHW-1:0]),
`ifdef PIPE_ALU_MUL_EN
        .b     (b),
`endif
        .done  (sh_done),
        .res   (sh_res),
        .cout  (sh_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // Used only to silence unused warnings when MUL is compiled out
    logic unused_mul;
    assign unused_mul = is_mul;

endmodule
